// File: rtl/lemming_world.sv
// Environment partner for a lemming walker FSM.
// Tracks the lemming on a walled 1-D track with pits and returns
// bump/ground feedback. Pits become solid ground once a lemming has fallen in.
//
// state   | meaning
// --------+--------------------------------------------------------------
// SURFACE | lemming stands on a cell; walks, bumps walls or finds a pit
// DROP    | lemming is falling into the pit under pos for FALL_DEPTH cycles
module lemming_world #(
   parameter int                WIDTH      = 8,
   parameter int                POS_W      = 3,
   parameter int                START_POS  = 0,
   parameter logic [WIDTH-1:0]  PIT_INIT   = '0,
   parameter int                FALL_DEPTH = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              walk_left,
   input  logic              walk_right,
   input  logic              aaah,
   input  logic              load,
   input  logic [WIDTH-1:0]  pit_map_in,
   output logic              bump_left,
   output logic              bump_right,
   output logic              ground,
   output logic [POS_W-1:0]  pos,
   output logic [WIDTH-1:0]  pit_map,
   output logic [POS_W:0]    fill_cnt,
   output logic              err
);

   localparam int               CNT_W    = (FALL_DEPTH > 1) ? $clog2(FALL_DEPTH) : 1;
   localparam logic [POS_W-1:0] POS_MAX  = POS_W'(WIDTH - 1);
   localparam logic [POS_W-1:0] POS_INIT = POS_W'(START_POS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FALL_DEPTH - 1);

   typedef enum logic {SURFACE = 1'b0, DROP = 1'b1} state_t;

   state_t             state, state_n;
   logic [CNT_W-1:0]   drop_cnt, drop_cnt_n;
   logic [POS_W-1:0]   pos_n;
   logic [WIDTH-1:0]   pit_map_n;
   logic [POS_W:0]     fill_cnt_n;
   logic               err_n;
   logic               violation;

   // Walker-facing feedback; a pit under a wall cell suppresses the bump.
   always_comb begin
      ground     = 1'b0;
      bump_left  = 1'b0;
      bump_right = 1'b0;
      if (state == SURFACE) begin
         ground     = ~pit_map[pos];
         bump_left  = ground & walk_left  & (pos == '0);
         bump_right = ground & walk_right & (pos == POS_MAX);
      end
   end

   // Next-state: movement, falling, pit filling and protocol checking.
   always_comb begin
      state_n    = state;
      drop_cnt_n = drop_cnt;
      pos_n      = pos;
      pit_map_n  = pit_map;
      fill_cnt_n = fill_cnt;
      violation  = !$onehot({walk_left, walk_right, aaah}) |
                   ((state == DROP) & ~aaah);
      err_n      = err | violation;
      case (state)
         SURFACE: begin
            if (!ground) begin
               state_n    = DROP;
               drop_cnt_n = '0;
            end else if (aaah) begin
               // walker still reports falling for one cycle after landing
               pos_n = pos;
            end else if (walk_left) begin
               if (pos != '0) pos_n = pos - 1'b1;
            end else if (walk_right) begin
               if (pos != POS_MAX) pos_n = pos + 1'b1;
            end
         end
         DROP: begin
            drop_cnt_n = drop_cnt + 1'b1;
            if (drop_cnt == CNT_LAST) begin
               state_n         = SURFACE;
               drop_cnt_n      = '0;
               pit_map_n[pos]  = 1'b0;
               if (fill_cnt != '1) fill_cnt_n = fill_cnt + 1'b1;
            end
         end
         default: state_n = SURFACE;
      endcase
   end

   // State register; load restarts the world but keeps the sticky error.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= SURFACE;
         drop_cnt <= '0;
         pos      <= POS_INIT;
         pit_map  <= PIT_INIT;
         fill_cnt <= '0;
         err      <= 1'b0;
      end else if (load) begin
         state    <= SURFACE;
         drop_cnt <= '0;
         pos      <= POS_INIT;
         pit_map  <= pit_map_in;
         fill_cnt <= '0;
         err      <= err_n;
      end else begin
         state    <= state_n;
         drop_cnt <= drop_cnt_n;
         pos      <= pos_n;
         pit_map  <= pit_map_n;
         fill_cnt <= fill_cnt_n;
         err      <= err_n;
      end
   end

endmodule

// File: tb/tb_lemming_world.sv
// Bench for lemming_world: directed walkthrough of the key scenarios followed
// by a randomized walker, all checked against a cell-level world model.
module tb_lemming_world;

   localparam int WIDTH = 8;
   localparam int DEPTH = 3;

   logic             clk = 1'b0;
   logic             reset, walk_left, walk_right, aaah, load;
   logic [7:0]       pit_map_in;
   logic             bump_left, bump_right, ground, err;
   logic [2:0]       pos;
   logic [7:0]       pit_map;
   logic [3:0]       fill_cnt;

   int total = 0;
   int bad   = 0;

   // world model: cell index, pit set, remaining fall cycles (0 = on surface)
   int        m_pos;
   bit [7:0]  m_pits;
   int        m_fall;
   int        m_fill;
   bit        m_err;

   lemming_world #(
      .WIDTH(8), .POS_W(3), .START_POS(0), .PIT_INIT(8'h00), .FALL_DEPTH(3)
   ) dut (
      .clk(clk), .reset(reset), .walk_left(walk_left), .walk_right(walk_right),
      .aaah(aaah), .load(load), .pit_map_in(pit_map_in),
      .bump_left(bump_left), .bump_right(bump_right), .ground(ground),
      .pos(pos), .pit_map(pit_map), .fill_cnt(fill_cnt), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit exp_ground();
      return (m_fall == 0) && !m_pits[m_pos];
   endfunction

   task automatic model_reset(input bit [7:0] pits);
      m_pos  = 0;
      m_pits = pits;
      m_fall = 0;
      m_fill = 0;
   endtask

   // one clock: drive, compare mid-cycle, then advance the model on the edge
   task automatic cyc(input logic wl, input logic wr, input logic aa,
                      input logic ld, input logic rs, input logic [7:0] pin);
      bit g, viol;
      walk_left  = wl;
      walk_right = wr;
      aaah       = aa;
      load       = ld;
      reset      = rs;
      pit_map_in = pin;
      @(negedge clk);
      g = exp_ground();
      chk("ground",     ground,     g);
      chk("bump_left",  bump_left,  g && wl && (m_pos == 0));
      chk("bump_right", bump_right, g && wr && (m_pos == WIDTH - 1));
      chk("pos",        pos,        m_pos);
      chk("pit_map",    pit_map,    m_pits);
      chk("fill_cnt",   fill_cnt,   m_fill);
      chk("err",        err,        m_err);
      @(posedge clk);
      #1;
      viol = ((int'(wl) + int'(wr) + int'(aa)) != 1) || (m_fall > 0 && !aa);
      if (rs) begin
         model_reset(8'h00);
         m_err = 1'b0;
      end else if (ld) begin
         model_reset(pin);
         m_err = m_err | viol;
      end else begin
         if (m_fall > 0) begin
            m_fall--;
            if (m_fall == 0) begin
               m_pits[m_pos] = 1'b0;
               m_fill = (m_fill < 15) ? m_fill + 1 : 15;
            end
         end else if (m_pits[m_pos]) begin
            m_fall = DEPTH;
         end else if (!aa) begin
            if (wl)      m_pos = (m_pos > 0) ? m_pos - 1 : 0;
            else if (wr) m_pos = (m_pos < WIDTH - 1) ? m_pos + 1 : WIDTH - 1;
         end
         m_err = m_err | viol;
      end
   endtask

   initial begin
      int r;
      logic wl, wr, aa, ld, rs;
      logic [7:0] pin;

      reset = 1'b1; load = 1'b0; walk_left = 1'b0; walk_right = 1'b1;
      aaah = 1'b0; pit_map_in = 8'h00;
      @(posedge clk);
      @(posedge clk);
      #1;
      model_reset(8'h00);
      m_err = 1'b0;

      // 1: bump the left wall
      repeat (3) cyc(1, 0, 0, 0, 0, 8'h00);
      chk("t1_pos", pos, 0);
      chk("t1_err", err, 0);

      // 2: walk to the right wall and bump it
      repeat (8) cyc(0, 1, 0, 0, 0, 8'h00);
      chk("t2_pos", pos, 7);

      // 3: load a pit at cell 3, walk into it, fall, land on filled ground
      cyc(0, 1, 0, 1, 0, 8'h08);
      repeat (3) cyc(0, 1, 0, 0, 0, 8'h00);
      chk("t3_pos", pos, 3);
      chk("t3_ground_pit", ground, 0);
      cyc(0, 1, 0, 0, 0, 8'h00);
      repeat (3) cyc(0, 0, 1, 0, 0, 8'h00);
      chk("t3_ground", ground, 1);
      chk("t3_pit_map", pit_map, 8'h00);
      chk("t3_fill", fill_cnt, 1);
      cyc(0, 0, 1, 0, 0, 8'h00);

      // 4: two-hot walker output sets a sticky error that survives load
      cyc(1, 1, 0, 0, 0, 8'h00);
      chk("t4_err", err, 1);
      cyc(0, 1, 0, 1, 0, 8'h00);
      chk("t4_err_load", err, 1);
      cyc(0, 1, 0, 0, 1, 8'h00);
      chk("t4_err_reset", err, 0);

      // 5: reset in the middle of a fall
      cyc(0, 1, 0, 1, 0, 8'h08);
      repeat (4) cyc(0, 1, 0, 0, 0, 8'h00);
      cyc(0, 0, 1, 0, 0, 8'h00);
      cyc(0, 0, 1, 0, 1, 8'h00);
      chk("t5_pos", pos, 0);
      chk("t5_pit_map", pit_map, 8'h00);
      chk("t5_fill", fill_cnt, 0);
      chk("t5_ground", ground, 1);

      // 6: reset beats load
      cyc(0, 1, 0, 1, 1, 8'hFF);
      chk("t6_pit_map", pit_map, 8'h00);
      chk("t6_pos", pos, 0);

      // randomized walker against the model
      for (int i = 0; i < 600; i++) begin
         r  = $urandom_range(0, 99);
         ld = ($urandom_range(0, 99) < 4);
         rs = ($urandom_range(0, 199) == 0);
         pin = 8'($urandom);
         wl = 1'b0; wr = 1'b0; aa = 1'b0;
         if (m_fall > 0 || !exp_ground()) begin
            if (r < 97) aa = 1'b1;
            else        wr = 1'b1;
         end else if (r < 45) wl = 1'b1;
         else if (r < 90)     wr = 1'b1;
         else if (r < 98)     aa = 1'b1;
         else if (r < 99)     begin wl = 1'b1; wr = 1'b1; end
         cyc(wl, wr, aa, ld, rs, pin);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
